// File: rtl/store_ecc_lane_encoder.sv
// Store-path DEC-TED check-bit generator: encodes one 32-bit lane per cycle through a
// single shared encoder pair and hands data/address/check bits to the cache write port.

// Shared encoder pair. A: Hamming-style syndrome over data positions 1..32 plus overall
// parity in bit 6. B: byte-column parity. Output layout {^B, B, A}.
module store_ecc_enc_pair (
  input  logic [31:0] d,
  output logic [15:0] chk
);
  logic [6:0] enc_a;
  logic [7:0] enc_b;

  always_comb begin
    enc_a = '0;
    for (int j = 0; j < 32; j++)
      for (int i = 0; i < 6; i++)
        if (((j + 1) & (1 << i)) != 0) enc_a[i] = enc_a[i] ^ d[j];
    enc_a[6] = ^d;
    for (int i = 0; i < 8; i++)
      enc_b[i] = d[i] ^ d[i+8] ^ d[i+16] ^ d[i+24];
  end

  assign chk = {^enc_b, enc_b, enc_a};
endmodule

module store_ecc_lane_encoder #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [LANES*32-1:0] in_data,
  input  logic                in_bypass,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [LANES*32-1:0] out_data,
  output logic [LANES*16-1:0] out_parity,
  output logic                busy,
  output logic [CNT_W-1:0]    store_count
);
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ENC, HOLD} state_t;

  state_t                  state;
  logic [LIDX_W-1:0]       lane_idx;
  logic [LANES-1:0][31:0]  data_q;
  logic [LANES-1:0][15:0]  par_q;
  logic [15:0]             enc_chk;
  logic                    accept;

  // Captured data doubles as the output register, so the encoder reads it directly.
  store_ecc_enc_pair u_enc (
    .d   (data_q[lane_idx]),
    .chk (enc_chk)
  );

  assign in_ready   = rst_n & ~flush & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign accept     = in_valid & in_ready;
  assign busy       = (state != IDLE);
  assign out_data   = data_q;
  assign out_parity = par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lane_idx    <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      data_q      <= '0;
      par_q       <= '0;
      store_count <= '0;
    end else begin
      if (out_valid && out_ready && !flush && (store_count != {CNT_W{1'b1}}))
        store_count <= store_count + CNT_W'(1);

      // flush beats both a new accept and the output handshake
      if (flush) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        lane_idx  <= '0;
      end else if (accept) begin
        out_addr <= in_addr;
        data_q   <= in_data;
        par_q    <= '0;
        lane_idx <= '0;
        if (in_bypass) begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end else begin
          state     <= ENC;
          out_valid <= 1'b0;
        end
      end else begin
        case (state)
          ENC: begin
            par_q[lane_idx] <= enc_chk;
            if (lane_idx == LAST_LANE) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              lane_idx  <= '0;
            end else begin
              lane_idx <= lane_idx + LIDX_W'(1);
            end
          end
          HOLD: begin
            if (out_ready) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_store_ecc_lane_encoder.sv
// Directed bench for store_ecc_lane_encoder with a queue scoreboard and a negedge monitor.
module tb_store_ecc_lane_encoder;
  localparam int LANES  = 4;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_addr;
  logic [LANES*32-1:0] in_data;
  logic                in_bypass;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [ADDR_W-1:0]   out_addr;
  logic [LANES*32-1:0] out_data;
  logic [LANES*16-1:0] out_parity;
  logic                busy;
  logic [CNT_W-1:0]    store_count;

  store_ecc_lane_encoder #(.LANES(LANES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_bypass(in_bypass), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_parity(out_parity), .busy(busy), .store_count(store_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [LANES*32-1:0] data;
    logic [LANES*16-1:0] par;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Hand-computed check bits: lane k = A5A5_0000+k, the lane-0/3 swap, and all-ones data
  localparam logic [127:0] D_A5  = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
  localparam logic [63:0]  P_A5  = 64'h01B3_8172_80F1_0030;
  localparam logic [127:0] D_SW  = {32'hA5A5_0000, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0003};
  localparam logic [63:0]  P_SW  = 64'h0030_8172_80F1_01B3;
  localparam logic [127:0] D_ONE = {128{1'b1}};
  localparam logic [63:0]  P_ONE = 64'h0020_0020_0020_0020;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits (bounded) for in_ready, and returns 1 ns after the accept edge.
  task automatic send(input logic [ADDR_W-1:0] a, input logic [127:0] d, input logic byp,
                      input logic [63:0] par, input bit expect_out);
    exp_t e;
    in_addr = a; in_data = d; in_bypass = byp; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("send_in_ready", in_ready, 1'b1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    if (expect_out) begin
      e.addr = a; e.data = d; e.par = par;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    in_addr  = ~a;
    in_data  = ~d;
  endtask

  task automatic expect_latency(input int n, input string name);
    chk({name, "_lat0"}, out_valid, 1'b0);
    for (int i = 1; i < n; i++) begin
      tick();
      chk({name, "_lat_lo"}, out_valid, 1'b0);
    end
    tick();
    chk({name, "_lat_hi"}, out_valid, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got addr %h with empty scoreboard", out_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("out_addr",   out_addr,   mon_e.addr);
        chk("out_data",   out_data,   mon_e.data);
        chk("out_parity", out_parity, mon_e.par);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  hold_par;
    logic [127:0] hold_data;
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; in_bypass = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid",   out_valid,   1'b0);
    chk("rst_in_ready",    in_ready,    1'b0);
    chk("rst_busy",        busy,        1'b0);
    chk("rst_store_count", store_count, 2'd0);
    chk("rst_out_parity",  out_parity,  64'h0);
    chk("rst_out_data",    out_data,    128'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // zero data, full encode
    send(10'h001, 128'h0, 1'b0, 64'h0, 1'b1);
    expect_latency(4, "zero");
    tick();
    chk("zero_count", store_count, 2'd1);
    chk("zero_idle",  busy, 1'b0);

    // flush in the lane_idx == 2 cycle
    send(10'h0F0, D_A5, 1'b0, 64'h0, 1'b0);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", out_valid,   1'b0);
    chk("flush_busy",      busy,        1'b0);
    chk("flush_count",     store_count, 2'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("flush_no_output", out_valid, 1'b0);

    // flush with in_valid in IDLE: nothing accepted
    in_valid = 1'b1; in_data = D_ONE; in_bypass = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_busy",      busy,      1'b0);
    chk("flush_idle_out_valid", out_valid, 1'b0);

    // A5 pattern with partial-slice check
    send(10'h155, D_A5, 1'b0, P_A5, 1'b1);
    tick(); tick();
    chk("a5_partial_lo", out_parity[31:0],  32'h80F1_0030);
    chk("a5_partial_hi", out_parity[63:32], 32'h0);
    tick(); tick();
    chk("a5_out_valid", out_valid, 1'b1);
    tick();
    chk("a5_count", store_count, 2'd2);

    // lanes 0 and 3 swapped
    send(10'h2AA, D_SW, 1'b0, P_SW, 1'b1);
    expect_latency(4, "swap");
    tick();
    chk("swap_count", store_count, 2'd3);

    // bypass
    send(10'h3FF, D_ONE, 1'b1, 64'h0, 1'b1);
    chk("byp_out_valid", out_valid, 1'b1);
    tick();
    chk("byp_count_sat", store_count, 2'd3);

    // backpressure, then back-to-back accept
    out_ready = 1'b0;
    send(10'h123, D_A5, 1'b0, P_A5, 1'b1);
    expect_latency(4, "bp");
    hold_par = out_parity; hold_data = out_data;
    chk("bp_par_first", hold_par, P_A5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", out_valid,  1'b1);
      chk("bp_in_ready",  in_ready,   1'b0);
      chk("bp_par",       out_parity, P_A5);
      chk("bp_data",      out_data,   D_A5);
      chk("bp_addr",      out_addr,   10'h123);
    end
    out_ready = 1'b1;
    send(10'h321, D_ONE, 1'b0, P_ONE, 1'b1);
    expect_latency(4, "b2b");
    tick();
    chk("b2b_count_sat", store_count, 2'd3);

    // reset mid-ENC
    send(10'h050, D_SW, 1'b0, 64'h0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", out_valid,   1'b0);
    chk("rstmid_in_ready",  in_ready,    1'b0);
    chk("rstmid_busy",      busy,        1'b0);
    chk("rstmid_count",     store_count, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(10'h077, D_A5, 1'b0, P_A5, 1'b1);
    expect_latency(4, "post_rst");
    tick();
    chk("post_rst_count", store_count, 2'd1);

    tick(); tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/store_ecc_lane_encoder.md
Name: store_ecc_lane_encoder

Overview:
- Multi-cycle DEC-TED check-bit generator on the store path between the pipeline and the data cache write port.
- Accepts a store word of LANES x 32 bits and encodes one 32-bit lane per cycle through a single shared Parity_Encoder_A / Parity_Encoder_B pair.
- Presents data, address and LANES x 16 check bits to the cache under a valid/ready handshake.
- Supports a per-transaction ECC bypass mode and a synchronous flush.

Parameters:
- LANES, 4, number of 32-bit lanes per store word; legal range is 1 or more.
- ADDR_W, 10, cache write address width.
- CNT_W, 16, width of the completed-store counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  block can accept a request.
- in_addr  in  ADDR_W  store address.
- in_data  in  LANES*32  store data; lane k is in_data[32k+31:32k].
- in_bypass  in  1  1 = skip encoding; check bits are all zero.
- flush  in  1  synchronous abort of any in-flight store.
- out_valid  out  1  encoded store available.
- out_ready  in  1  cache accepts the store.
- out_addr  out  ADDR_W  captured address.
- out_data  out  LANES*32  captured data.
- out_parity  out  LANES*16  check bits; lane k is out_parity[16k+15:16k].
- busy  out  1  high in ENC or HOLD.
- store_count  out  CNT_W  saturating count of completed output handshakes.

Behaviour:
- Per-lane check-bit layout, for lane data d:
  - bits [6:0] = Parity_Encoder_A(d).
  - bits [14:7] = Parity_Encoder_B(d).
  - bit [15] = XOR of bits [14:7].
- FSM has three states: IDLE, ENC, HOLD.
- Reset (rst_n low, asynchronous):
  - state = IDLE, lane_idx = 0.
  - out_valid = 0, out_addr = 0, out_data = 0, out_parity = 0, store_count = 0.
  - in_ready is forced to 0 while rst_n is low.
- in_ready = rst_n & !flush & (IDLE | (HOLD & out_ready)). This is a combinational path from out_ready.
- Accept occurs when in_valid & in_ready at a rising edge:
  - Capture addr, data and bypass; clear out_parity; set lane_idx = 0.
  - If bypass = 0, go to ENC.
  - If bypass = 1, go to HOLD with out_parity = 0 and out_valid = 1 on the next cycle (latency 1).
- ENC:
  - Each cycle, the shared encoder pair encodes captured lane lane_idx; the result is written to out_parity slice lane_idx at the edge.
  - lane_idx increments by one per cycle.
  - When lane_idx = LANES-1, the edge writes the last slice, moves to HOLD, sets out_valid = 1 and resets lane_idx to 0.
  - Latency from accept edge to out_valid is LANES cycles. For LANES = 1 this is 1 cycle.
- In ENC, out_valid = 0 and in_ready = 0. Slices not yet written read 0.
- HOLD:
  - out_valid = 1; all outputs are held stable until out_ready.
  - If out_ready at an edge with no new accept: go to IDLE, out_valid = 0.
  - If out_ready and in_valid at the same edge: back-to-back accept with no IDLE bubble; the next state follows the new request's bypass bit.
- store_count increments by 1 on each out_valid & out_ready edge and saturates at 2^CNT_W-1. It is not cleared by flush.
- flush high at an edge:
  - From ENC or HOLD, go to IDLE and set out_valid = 0. The partial store is discarded; no handshake is counted.
  - flush takes priority over both accept and output handshake in the same cycle.
  - Captured data registers are not required to clear.
- in_data and in_addr are don't-care when not accepting. Changes to inputs during ENC have no effect.
- Reset asserted mid-ENC or mid-HOLD returns the block to the reset values immediately. No output handshake completes.
- busy = (state != IDLE).

Test Plan:
- LANES = 4, in_data = 0, bypass = 0:
  - out_valid rises exactly 4 cycles after the accept edge.
  - out_parity = 0, out_data = 0, and store_count = 1 after out_ready.
- LANES = 4, lane k = 32'hA5A5_0000 + k:
  - Each out_parity slice k equals the standalone encoder pair output for that lane value.
  - Bit [16k+15] of each slice equals the XOR of bits [16k+14:16k+7].
  - Swapping lanes 0 and 3 swaps their slices.
- bypass = 1 with data 32'hFFFF_FFFF in every lane:
  - out_valid one cycle after accept; out_parity = 0; out_data matches the input.
- Backpressure: hold out_ready = 0 for 5 cycles in HOLD:
  - Outputs are stable and in_ready = 0.
  - Raise out_ready with in_valid high: a new accept happens at the same edge, and the second result appears 4 cycles later.
- Flush:
  - Assert flush in the ENC cycle where lane_idx = 2: next cycle is IDLE, out_valid = 0, store_count unchanged.
  - flush together with in_valid in IDLE: no accept occurs.
- Reset and saturation:
  - Drop rst_n mid-ENC: out_valid = 0 and in_ready = 0 immediately.
  - After release, a normal store completes in 4 cycles.
  - With CNT_W = 2, five handshakes leave store_count = 3.
